// File: rtl/mux16_rr_arbiter_if.sv
// rtl/mux16_rr_arbiter_if.sv - request/data/grant bundle for the 16:1 round-robin mux arbiter
interface mux16_rr_arbiter_if;
    logic [15:0] req;
    logic [15:0] in;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        valid;
    logic        out;

    modport master (
        output req,
        output in,
        input  grant,
        input  sel,
        input  valid,
        input  out
    );

    modport slave (
        input  req,
        input  in,
        output grant,
        output sel,
        output valid,
        output out
    );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// rtl/mux16_rr_arbiter.sv - 16-way round-robin arbiter driving a shared 16:1 mux; MUX16_ARB_TIMEOUT_EN enables the MAX_HOLD grant limit
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    mux16_rr_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

`ifdef MUX16_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

    state_t      state, state_n;
    logic [3:0]  ptr, ptr_n;
    logic [3:0]  sel_q, sel_n;
    logic [15:0] grant_q, grant_n;
    logic        valid_q, valid_n;
    logic [4:0]  hold_cnt, hold_n;

    logic [3:0]  win;
    logic [3:0]  idx;
    logic        found;
    logic [4:0]  hold_inc;
    logic        release_now;

    // Scan from ptr in wrap order; the first set request wins.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            idx = ptr + 4'(k);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign hold_inc    = (hold_cnt == 5'd31) ? hold_cnt : hold_cnt + 5'd1;
    assign release_now = !bus.req[sel_q] || (TIMEOUT_ON && (hold_cnt == HOLD_LAST));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel_q;
        grant_n = grant_q;
        valid_n = valid_q;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (bus.req != 16'h0000) begin
                    state_n = GRANT;
                    sel_n   = win;
                    grant_n = 16'b1 << win;
                    valid_n = 1'b1;
                    hold_n  = 5'd0;
                end
            end
            GRANT: begin
                hold_n = hold_inc;
                // Release always passes through IDLE so grants never switch back-to-back.
                if (release_now) begin
                    state_n = IDLE;
                    grant_n = 16'h0000;
                    valid_n = 1'b0;
                    ptr_n   = sel_q + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 16'h0000;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 4'd0;
            sel_q    <= 4'd0;
            grant_q  <= 16'h0000;
            valid_q  <= 1'b0;
            hold_cnt <= 5'd0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            sel_q    <= sel_n;
            grant_q  <= grant_n;
            valid_q  <= valid_n;
            hold_cnt <= hold_n;
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
    assign bus.out   = valid_q ? bus.in[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb/tb_mux16_rr_arbiter.sv - directed scoreboard bench for mux16_rr_arbiter
module tb_mux16_rr_arbiter;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   exp_q[$];
    int   cur_exp;
    logic prev_valid;

    mux16_rr_arbiter_if bus ();

    mux16_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every rising valid must match the next queued requester.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (bus.valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 16'd0, 16'd1);
                end else begin
                    chk("sb_sel", {12'd0, bus.sel}, 16'(exp_q[0]));
                    chk("sb_grant", bus.grant, 16'b1 << exp_q[0]);
                    cur_exp <= exp_q[0];
                    void'(exp_q.pop_front());
                end
            end else if (bus.valid) begin
                chk("sb_hold_grant", bus.grant, 16'b1 << cur_exp);
            end
            prev_valid <= bus.valid;
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        cur_exp    = 0;
        rst        = 1'b1;
        bus.req    = 16'h0000;
        bus.in     = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_grant", bus.grant, 16'h0000);
        chk("rst_valid", {15'd0, bus.valid}, 16'd0);
        chk("rst_sel", {12'd0, bus.sel}, 16'd0);
        chk("rst_out", {15'd0, bus.out}, 16'd0);

        // Scenario 1: single request, one-edge latency
        rst     = 1'b0;
        bus.req = 16'h0001;
        bus.in  = 16'h0001;
        exp_q.push_back(0);
        @(negedge clk);
        chk("s1_grant", bus.grant, 16'h0001);
        chk("s1_sel", {12'd0, bus.sel}, 16'd0);
        chk("s1_valid", {15'd0, bus.valid}, 16'd1);
        chk("s1_out", {15'd0, bus.out}, 16'd1);
        bus.req = 16'h0000;
        @(negedge clk);
        chk("s1_release_valid", {15'd0, bus.valid}, 16'd0);
        chk("s1_release_sel", {12'd0, bus.sel}, 16'd0);
        chk("s1_release_out", {15'd0, bus.out}, 16'd0);

        // Scenario 2: all requesting, round-robin 0..15 then 0
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        bus.in  = 16'hAAAA;
        bus.req = 16'hFFFF;
        for (int g = 0; g < 17; g++) exp_q.push_back(g % 16);
        for (int g = 0; g < 17; g++) begin
            @(negedge clk);
            chk("s2_valid", {15'd0, bus.valid}, 16'd1);
            chk("s2_sel", {12'd0, bus.sel}, 16'(g % 16));
            chk("s2_out", {15'd0, bus.out}, 16'(g % 2));
            if (g == 16) begin
                bus.req = 16'h0000;
            end else begin
                bus.req[g % 16] = 1'b0;
            end
            @(negedge clk);
            chk("s2_gap", {15'd0, bus.valid}, 16'd0);
            bus.req = (g == 16) ? 16'h0000 : 16'hFFFF;
        end

        // Scenario 3: wrap past 14/15, then pointer at 1 finds 3
        bus.req = 16'h2000;
        exp_q.push_back(13);
        @(negedge clk);
        chk("s3_sel13", {12'd0, bus.sel}, 16'd13);
        bus.req = 16'h0000;
        @(negedge clk);
        chk("s3_rel13", {15'd0, bus.valid}, 16'd0);
        bus.req = 16'h0009;
        exp_q.push_back(0);
        @(negedge clk);
        chk("s3_wrap_sel", {12'd0, bus.sel}, 16'd0);
        bus.req = 16'h0008;
        exp_q.push_back(3);
        @(negedge clk);
        chk("s3_rel0", {15'd0, bus.valid}, 16'd0);
        @(negedge clk);
        chk("s3_sel3", {12'd0, bus.sel}, 16'd3);
        bus.req = 16'h0F0F;
        @(negedge clk);
        chk("s3_other_req_sel", {12'd0, bus.sel}, 16'd3);
        chk("s3_other_req_grant", bus.grant, 16'h0008);
        bus.req = 16'h0000;
        @(negedge clk);
        chk("s3_rel3", {15'd0, bus.valid}, 16'd0);

`ifdef MUX16_ARB_TIMEOUT_EN
        // Scenario 4: timeout forces release after MAX_HOLD cycles
        bus.req = 16'h0020;
        exp_q.push_back(5);
        exp_q.push_back(5);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("s4_valid_hi", {15'd0, bus.valid}, 16'd1);
            chk("s4_sel", {12'd0, bus.sel}, 16'd5);
        end
        @(negedge clk);
        chk("s4_timeout_gap", {15'd0, bus.valid}, 16'd0);
        @(negedge clk);
        chk("s4_regrant", {15'd0, bus.valid}, 16'd1);
        chk("s4_regrant_sel", {12'd0, bus.sel}, 16'd5);
        bus.req = 16'h0000;
        @(negedge clk);
        chk("s4_rel", {15'd0, bus.valid}, 16'd0);
`else
        // Scenario 5: no cycle limit without the timeout option
        bus.req = 16'h0020;
        exp_q.push_back(5);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("s5_valid_hi", {15'd0, bus.valid}, 16'd1);
            chk("s5_sel", {12'd0, bus.sel}, 16'd5);
        end
        bus.req = 16'h0000;
        @(negedge clk);
        chk("s5_rel", {15'd0, bus.valid}, 16'd0);
`endif

        // Scenario 6: asynchronous reset mid-grant, restart from ptr 0
        bus.req = 16'h0200;
        bus.in  = 16'h0200;
        exp_q.push_back(9);
        @(negedge clk);
        chk("s6_sel9", {12'd0, bus.sel}, 16'd9);
        chk("s6_out9", {15'd0, bus.out}, 16'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("s6_async_grant", bus.grant, 16'h0000);
        chk("s6_async_valid", {15'd0, bus.valid}, 16'd0);
        chk("s6_async_sel", {12'd0, bus.sel}, 16'd0);
        chk("s6_async_out", {15'd0, bus.out}, 16'd0);
        bus.req = 16'h0300;
        bus.in  = 16'h0100;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(8);
        @(negedge clk);
        chk("s6_first_sel", {12'd0, bus.sel}, 16'd8);
        chk("s6_first_out", {15'd0, bus.out}, 16'd1);
        bus.req = 16'h0000;
        @(negedge clk);
        chk("s6_rel", {15'd0, bus.valid}, 16'd0);
        chk("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mux16_rr_arbiter.md
MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, sets the maximum grant length in cycles (legal range 1..16); it is used only when MUX16_ARB_TIMEOUT_EN is defined.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 Port req, input, 16 bits: request lines; req[i] high means requester i wants the shared 16:1 mux.
REQ-005 Port in, input, 16 bits: mux data; in[i] is requester i's data bit.
REQ-006 Port grant, output, 16 bits: registered one-hot grant, or all-zero when idle.
REQ-007 Port sel, output, 4 bits: registered mux select, equal to the index of the granted requester.
REQ-008 Port valid, output, 1 bit: registered; high exactly when grant is non-zero.
REQ-009 Port out, output, 1 bit: combinational; equals in[sel] when valid is high, else 0.

Function
REQ-010 The block SHALL have two states, IDLE and GRANT, plus a 4-bit round-robin pointer ptr and a 5-bit hold counter hold_cnt.
REQ-011 In IDLE with req == 0, the block SHALL stay in IDLE with all outputs unchanged.
REQ-012 In IDLE with req != 0, the next edge SHALL enter GRANT, set sel to the first i with req[i]=1 searching ptr, ptr+1, ... with 15 wrapping to 0, set grant to one-hot(i), set valid to 1 and clear hold_cnt.
REQ-013 Latency from a request seen in IDLE to grant/valid high SHALL be exactly one clock edge.
REQ-014 In GRANT, hold_cnt SHALL increment by 1 each cycle and saturate at 31.
REQ-015 In GRANT with req[sel]=0 at an edge, the block SHALL go to IDLE, clear grant and valid, set ptr=sel+1 mod 16 and keep sel.
REQ-016 Between consecutive grants there SHALL be at least one IDLE cycle with valid low; grants are never switched back-to-back.
REQ-017 Changes to req bits other than req[sel] during GRANT SHALL NOT affect the current grant.
REQ-018 grant SHALL never have more than one bit set, and sel SHALL always equal the index of the set grant bit while valid is high.
REQ-019 With a single persistent requester i, the block SHALL re-grant i after each release, with the IDLE gap between grants.
REQ-020 When several bits of req rise in the same cycle, the one nearest ptr in wrap order SHALL win.

Reset
REQ-021 While rst is high, the block SHALL immediately and asynchronously force state=IDLE, grant=0, sel=0, valid=0, ptr=0 and hold_cnt=0, so out=0.
REQ-022 Reset asserted mid-grant SHALL abort the grant with no completion cycle; after rst falls, arbitration restarts from ptr=0.

Configuration
REQ-023 With macro MUX16_ARB_TIMEOUT_EN defined, the block SHALL force a release (same actions as REQ-015) at the edge where hold_cnt == MAX_HOLD-1 in GRANT, even if req[sel] is still high.
REQ-024 Without MUX16_ARB_TIMEOUT_EN, the block SHALL hold the grant until req[sel] drops, with no cycle limit, and MAX_HOLD SHALL have no effect.

Verification
REQ-025 Scenario 1: rst=1, then rst=0 with req=16'h0001 and in=16'h0001 -> one edge later grant=16'h0001, sel=0, valid=1, out=1.
REQ-026 Scenario 2: req=16'hFFFF held, each requester dropping its req one cycle after being granted -> grant order is 0,1,2,...,15,0 with one valid-low cycle between grants.
REQ-027 Scenario 3: ptr=14 after releasing requester 13, then req=16'h0009 -> sel=0 (wrap past 14 and 15); on release ptr=1; the next grant is sel=3.
REQ-028 Scenario 4 (TIMEOUT_EN, MAX_HOLD=4): req=16'h0020 held constantly -> valid high for 4 cycles, low for 1, then sel=5 again.
REQ-029 Scenario 5 (no TIMEOUT_EN): req=16'h0020 held for 40 cycles -> valid stays high all 40 cycles with sel=5.
REQ-030 Scenario 6: rst pulsed while sel=9 and valid=1 -> grant=0, valid=0 and sel=0 take effect before the next clock edge; with req=16'h0300, the first grant after reset is sel=8.
